reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-status scoreboard and write-port sequencer for the 32-entry architectural register file. Tracks, per register, whether a result is still outstanding and which ROB tag produces it. Accepts commits from the ROB and drives the register file's single write port (`set_reg`/`set_val`) through a registered write stage. Sits between issue/dispatch, the ROB commit path and the register file.

## Interface
- `TAG_WIDTH`, 4: ROB tag width (16 in-flight entries).
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `rdy_in`  in  1  global ready; when low, all state holds.
- `issue_valid`  in  1  rename request this cycle.
- `issue_rd`  in  5  destination register being renamed.
- `issue_tag`  in  TAG_WIDTH  ROB tag of the new producer.
- `commit_valid`  in  1  ROB commits one instruction.
- `commit_rd`  in  5  committed destination.
- `commit_tag`  in  TAG_WIDTH  ROB tag of the committing entry.
- `commit_val`  in  32  committed result.
- `flush_in`  in  1  mispredict flush; drops all speculative renames.
- `qry_reg_1`, `qry_reg_2`  in  5  source registers queried by dispatch.
- `qry_busy_1`, `qry_busy_2`  out  1  register has an outstanding producer (combinational).
- `qry_tag_1`, `qry_tag_2`  out  TAG_WIDTH  producer tag; 0 when not busy.
- `qry_fwd_1`, `qry_fwd_2`  out  1  value is available on `qry_val_*` this cycle.
- `qry_val_1`, `qry_val_2`  out  32  forwarded value; 0 when `qry_fwd_*` is 0.
- `set_reg`  out  5  register-file write index (registered); 0 means no write.
- `set_val`  out  32  register-file write data (registered).

## Operation
- State: `busy[31:0]`, `tag[31:0][TAG_WIDTH-1:0]`, and a write stage `wr_reg`/`wr_val`/`wr_tag`/`wr_vld` driving `set_reg`/`set_val`.
- Issue with `rd != 0` sets `busy[rd] = 1` and `tag[rd] = issue_tag`. Issue to x0 is ignored.
- Commit loads the write stage with `wr_reg = commit_rd`, `wr_val = commit_val` and `wr_tag = commit_tag`. With no commit, or a commit to x0, the stage loads `wr_reg = 0`.
- Busy clear: `busy[rd]` clears only if `tag[rd]` still equals the committing tag. When it clears is set by the Configuration section.
- Issue and busy-clear on the same `rd` in the same cycle: issue wins; busy stays 1 with the new tag.
- Flush: clears all `busy`/`tag` on the next edge. A commit in the same cycle still enters the write stage and is written. A same-cycle issue is dropped. A pending write-stage entry still completes.
- Queries: `qry_busy_*`/`qry_tag_*` reflect table state; x0 always reads as not busy, tag 0.
- `rdy_in` low: the table and write stage hold, and `set_reg`/`set_val` keep their values. The register file also gates on `rdy_in`, so no duplicate write occurs.

## Timing
- Reset values: all `busy` 0, all `tag` 0, `set_reg` 0, `set_val` 0, all `qry_*` outputs 0 for queried registers.
- Commit on edge N: `set_reg`/`set_val` valid after edge N. The register file captures at edge N+1, and a read returns the new value from cycle N+1 on.
- Query outputs are combinational from current state plus the write stage, with zero latency.
- Reset asserted mid-operation clears everything immediately. Any pending write stage is discarded.

## Configuration
- `SCOREBOARD_FWD_EN` defined:
  - busy-clear happens at the commit edge N.
  - `qry_fwd_*`=1 and `qry_val_*`=`set_val` when `qry_reg_*` equals `wr_reg`, `wr_reg != 0` and the register is not busy. This covers the cycle before the register file holds the value.
- Not defined:
  - busy-clear is delayed to edge N+1, performed from the write stage with a `wr_tag` match check.
  - `qry_fwd_*`/`qry_val_*` are tied 0.
  - Dispatch therefore sees busy until the register file holds the value.

## Test plan
- Reset, then query x5 -> busy 0, tag 0, `set_reg` 0.
- Issue rd=5 tag=3, next cycle query x5 -> busy 1, tag 3. Commit rd=5 tag=3 val=0xDEADBEEF -> `set_reg`=5, `set_val`=0xDEADBEEF next cycle. With FWD: busy 0 and fwd 1/val 0xDEADBEEF in that cycle. Without FWD: busy 1 that cycle and 0 the next.
- Issue rd=7 tag=2, issue rd=7 tag=9, commit rd=7 tag=2 -> x7 stays busy with tag 9, and the write of x7 still occurs.
- Same cycle: issue rd=4 tag=6 and commit rd=4 tag=1 (old tag 1) -> busy 1, tag 6.
- Issue rd=0 tag=5 and commit rd=0 -> x0 never busy, `set_reg` stays 0.
- Busy x1/x2/x3, then flush with a same-cycle commit rd=2 val=0x55 and issue rd=8 -> all busy 0, x8 not busy, `set_reg`=2/`set_val`=0x55. Assert `rst_in` with the write stage loaded -> `set_reg` 0 immediately.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy/tag scoreboard plus a registered
// register-file write stage fed by ROB commits.
// Build option: SCOREBOARD_FWD_EN -- clear busy at the commit edge and
// forward the write-stage value to dispatch queries.
module reg_scoreboard #(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  input  logic [TAG_WIDTH-1:0] issue_tag,
  input  logic                 commit_valid,
  input  logic [4:0]           commit_rd,
  input  logic [TAG_WIDTH-1:0] commit_tag,
  input  logic [31:0]          commit_val,
  input  logic                 flush_in,
  input  logic [4:0]           qry_reg_1,
  input  logic [4:0]           qry_reg_2,
  output logic                 qry_busy_1,
  output logic                 qry_busy_2,
  output logic [TAG_WIDTH-1:0] qry_tag_1,
  output logic [TAG_WIDTH-1:0] qry_tag_2,
  output logic                 qry_fwd_1,
  output logic                 qry_fwd_2,
  output logic [31:0]          qry_val_1,
  output logic [31:0]          qry_val_2,
  output logic [4:0]           set_reg,
  output logic [31:0]          set_val
);

  logic [31:0]          busy_q, busy_d;
  logic [TAG_WIDTH-1:0] tag_q [32];
  logic [TAG_WIDTH-1:0] tag_d [32];
  logic [4:0]           wr_reg;
  logic [31:0]          wr_val;
  logic                 wr_vld;
`ifndef SCOREBOARD_FWD_EN
  logic [TAG_WIDTH-1:0] wr_tag;
`endif

  // Next table state: busy-clear first, then flush or issue so issue wins
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < 32; i++) tag_d[i] = tag_q[i];
`ifdef SCOREBOARD_FWD_EN
    if (commit_valid && commit_rd != '0 && tag_q[commit_rd] == commit_tag) begin
      busy_d[commit_rd] = 1'b0;
      tag_d[commit_rd]  = '0;
    end
`else
    // clear one cycle late, from the write stage, only if no newer producer
    if (wr_vld && tag_q[wr_reg] == wr_tag) begin
      busy_d[wr_reg] = 1'b0;
      tag_d[wr_reg]  = '0;
    end
`endif
    if (flush_in) begin
      busy_d = '0;
      for (int unsigned i = 0; i < 32; i++) tag_d[i] = '0;
    end else if (issue_valid && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
      tag_d[issue_rd]  = issue_tag;
    end
  end

  // Scoreboard table register, frozen while rdy_in is low
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < 32; i++) tag_q[i] <= '0;
    end else if (rdy_in) begin
      busy_q <= busy_d;
      for (int unsigned i = 0; i < 32; i++) tag_q[i] <= tag_d[i];
    end
  end

  // Write stage: captures the commit, or an idle (x0) slot
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_reg <= '0;
      wr_val <= '0;
      wr_vld <= 1'b0;
`ifndef SCOREBOARD_FWD_EN
      wr_tag <= '0;
`endif
    end else if (rdy_in) begin
      if (commit_valid) begin
        wr_reg <= commit_rd;
        wr_val <= commit_val;
        wr_vld <= (commit_rd != '0);
`ifndef SCOREBOARD_FWD_EN
        wr_tag <= commit_tag;
`endif
      end else begin
        wr_reg <= '0;
        wr_vld <= 1'b0;
      end
    end
  end

  assign set_reg = wr_reg;
  assign set_val = wr_val;

  // Dispatch queries: table lookup, plus write-stage forwarding when enabled
  always_comb begin
    qry_busy_1 = (qry_reg_1 != '0) && busy_q[qry_reg_1];
    qry_busy_2 = (qry_reg_2 != '0) && busy_q[qry_reg_2];
    qry_tag_1  = qry_busy_1 ? tag_q[qry_reg_1] : '0;
    qry_tag_2  = qry_busy_2 ? tag_q[qry_reg_2] : '0;
`ifdef SCOREBOARD_FWD_EN
    qry_fwd_1  = wr_vld && (qry_reg_1 == wr_reg) && !busy_q[qry_reg_1];
    qry_fwd_2  = wr_vld && (qry_reg_2 == wr_reg) && !busy_q[qry_reg_2];
    qry_val_1  = qry_fwd_1 ? wr_val : '0;
    qry_val_2  = qry_fwd_2 ? wr_val : '0;
`else
    qry_fwd_1  = 1'b0;
    qry_fwd_2  = 1'b0;
    qry_val_1  = '0;
    qry_val_2  = '0;
`endif
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table-driven directed vectors for reg_scoreboard plus
// hand-written stall and mid-operation reset sequences.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
  localparam bit F = 1'b1;
`else
  localparam bit F = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, commit_valid, flush_in;
  logic [4:0]  issue_rd, commit_rd, qry_reg_1, qry_reg_2;
  logic [3:0]  issue_tag, commit_tag;
  logic [31:0] commit_val;
  logic        qry_busy_1, qry_busy_2, qry_fwd_1, qry_fwd_2;
  logic [3:0]  qry_tag_1, qry_tag_2;
  logic [31:0] qry_val_1, qry_val_2, set_val;
  logic [4:0]  set_reg;

  int checks = 0;
  int failures = 0;

  reg_scoreboard #(.TAG_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
    .commit_val(commit_val), .flush_in(flush_in),
    .qry_reg_1(qry_reg_1), .qry_reg_2(qry_reg_2),
    .qry_busy_1(qry_busy_1), .qry_busy_2(qry_busy_2),
    .qry_tag_1(qry_tag_1), .qry_tag_2(qry_tag_2),
    .qry_fwd_1(qry_fwd_1), .qry_fwd_2(qry_fwd_2),
    .qry_val_1(qry_val_1), .qry_val_2(qry_val_2),
    .set_reg(set_reg), .set_val(set_val)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int iv, ird, itag, cv, crd, ctag, cval, fl, q1, q2;
    int eb1, et1, ef1, ev1, eb2, et2, ef2, ev2, esr, esv, csv;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid  = v.iv[0];   issue_rd  = v.ird[4:0];  issue_tag  = v.itag[3:0];
    commit_valid = v.cv[0];   commit_rd = v.crd[4:0];  commit_tag = v.ctag[3:0];
    commit_val   = v.cval;    flush_in  = v.fl[0];
    qry_reg_1    = v.q1[4:0]; qry_reg_2 = v.q2[4:0];
  endtask

  task automatic idle();
    issue_valid = 1'b0; commit_valid = 1'b0; flush_in = 1'b0;
    issue_rd = '0; issue_tag = '0; commit_rd = '0; commit_tag = '0; commit_val = '0;
  endtask

  initial begin
    // iv ird itag | cv crd ctag cval | fl | q1 q2 | eb1 et1 ef1 ev1 | eb2 et2 ef2 ev2 | esr esv csv
    vec[0]  = '{1,5,3, 0,0,0,0, 0, 5,0, 1,3,0,0, 0,0,0,0, 0,0,1};
    vec[1]  = '{0,0,0, 1,5,3,32'hDEADBEEF, 0, 5,0, F?0:1, F?0:3, F?1:0, F?32'hDEADBEEF:0,
                0,0,0,0, 5,32'hDEADBEEF,1};
    vec[2]  = '{0,0,0, 0,0,0,0, 0, 5,0, 0,0,0,0, 0,0,0,0, 0,32'hDEADBEEF,1};
    vec[3]  = '{1,7,2, 0,0,0,0, 0, 7,0, 1,2,0,0, 0,0,0,0, 0,32'hDEADBEEF,1};
    vec[4]  = '{1,7,9, 0,0,0,0, 0, 7,0, 1,9,0,0, 0,0,0,0, 0,32'hDEADBEEF,1};
    vec[5]  = '{0,0,0, 1,7,2,32'h1234, 0, 7,0, 1,9,0,0, 0,0,0,0, 7,32'h1234,1};
    vec[6]  = '{0,0,0, 0,0,0,0, 0, 7,0, 1,9,0,0, 0,0,0,0, 0,32'h1234,1};
    vec[7]  = '{1,4,1, 0,0,0,0, 0, 4,7, 1,1,0,0, 1,9,0,0, 0,32'h1234,1};
    vec[8]  = '{1,4,6, 1,4,1,32'hAA, 0, 4,0, 1,6,0,0, 0,0,0,0, 4,32'hAA,1};
    vec[9]  = '{0,0,0, 0,0,0,0, 0, 4,0, 1,6,0,0, 0,0,0,0, 0,32'hAA,1};
    vec[10] = '{1,0,5, 1,0,5,32'h77, 0, 0,4, 0,0,0,0, 1,6,0,0, 0,0,0};
    vec[11] = '{1,1,1, 0,0,0,0, 0, 1,0, 1,1,0,0, 0,0,0,0, 0,0,0};
    vec[12] = '{1,2,2, 0,0,0,0, 0, 2,0, 1,2,0,0, 0,0,0,0, 0,0,0};
    vec[13] = '{1,3,3, 0,0,0,0, 0, 3,1, 1,3,0,0, 1,1,0,0, 0,0,0};
    vec[14] = '{1,8,4, 1,2,2,32'h55, 1, 8,2, 0,0,0,0, 0,0,F?1:0,F?32'h55:0, 2,32'h55,1};
    vec[15] = '{0,0,0, 0,0,0,0, 0, 3,1, 0,0,0,0, 0,0,0,0, 0,32'h55,1};

    rst_in = 1'b1; rdy_in = 1'b1; idle();
    qry_reg_1 = 5'd5; qry_reg_2 = 5'd0;
    #12;
    chk("rst_busy5", int'(qry_busy_1), 0);
    chk("rst_tag5",  int'(qry_tag_1), 0);
    chk("rst_set_reg", int'(set_reg), 0);
    chk("rst_set_val", int'(set_val), 0);
    chk("rst_fwd5", int'(qry_fwd_1), 0);
    @(negedge clk_in); rst_in = 1'b0;

    for (int k = 0; k < 16; k++) begin
      drive(vec[k]);
      @(posedge clk_in); #1;
      chk($sformatf("v%0d_busy1", k), int'(qry_busy_1), vec[k].eb1);
      chk($sformatf("v%0d_tag1", k),  int'(qry_tag_1),  vec[k].et1);
      chk($sformatf("v%0d_fwd1", k),  int'(qry_fwd_1),  vec[k].ef1);
      chk($sformatf("v%0d_val1", k),  int'(qry_val_1),  vec[k].ev1);
      chk($sformatf("v%0d_busy2", k), int'(qry_busy_2), vec[k].eb2);
      chk($sformatf("v%0d_tag2", k),  int'(qry_tag_2),  vec[k].et2);
      chk($sformatf("v%0d_fwd2", k),  int'(qry_fwd_2),  vec[k].ef2);
      chk($sformatf("v%0d_val2", k),  int'(qry_val_2),  vec[k].ev2);
      chk($sformatf("v%0d_set_reg", k), int'(set_reg), vec[k].esr);
      if (vec[k].csv != 0)
        chk($sformatf("v%0d_set_val", k), int'(set_val), vec[k].esv);
    end

    // Load the write stage with x9 while x10 is busy
    idle(); issue_valid = 1'b1; issue_rd = 5'd10; issue_tag = 4'd5;
    @(posedge clk_in); #1;
    idle(); commit_valid = 1'b1; commit_rd = 5'd9; commit_tag = 4'd1; commit_val = 32'h99;
    qry_reg_1 = 5'd10; qry_reg_2 = 5'd9;
    @(posedge clk_in); #1;
    chk("ld_set_reg", int'(set_reg), 9);
    chk("ld_set_val", int'(set_val), 32'h99);
    chk("ld_busy10", int'(qry_busy_1), 1);
    chk("ld_tag10", int'(qry_tag_1), 5);
    chk("ld_fwd9", int'(qry_fwd_2), F ? 1 : 0);
    chk("ld_val9", int'(qry_val_2), F ? 32'h99 : 0);

    // Stall: commit and issue presented with rdy_in low must be ignored
    rdy_in = 1'b0;
    idle(); commit_valid = 1'b1; commit_rd = 5'd11; commit_tag = 4'd2; commit_val = 32'h11;
    issue_valid = 1'b1; issue_rd = 5'd12; issue_tag = 4'd7;
    qry_reg_1 = 5'd12; qry_reg_2 = 5'd10;
    @(posedge clk_in); #1;
    chk("stall_set_reg", int'(set_reg), 9);
    chk("stall_set_val", int'(set_val), 32'h99);
    chk("stall_busy12", int'(qry_busy_1), 0);
    chk("stall_busy10", int'(qry_busy_2), 1);
    chk("stall_tag10", int'(qry_tag_2), 5);

    // Asynchronous reset with the write stage loaded
    idle(); rdy_in = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    chk("arst_set_reg", int'(set_reg), 0);
    chk("arst_set_val", int'(set_val), 0);
    chk("arst_busy10", int'(qry_busy_2), 0);
    chk("arst_tag10", int'(qry_tag_2), 0);
    @(negedge clk_in); rst_in = 1'b0;
    @(posedge clk_in); #1;
    chk("post_set_reg", int'(set_reg), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
